m_encode_par: RTL

- Parametrised message encoder for the lattice KEM datapath.
- Accepts an N-bit message in IN_W-bit beats over a valid/ready handshake, then maps every bit to a modular coefficient: (OFFSET + bit*SCALE) mod Q.
- Encodes LANES coefficients per cycle and presents all N coefficients on a flat bus to the downstream polynomial adder.

---
 rtl/m_encode_par.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/m_encode_par.sv
// m_encode_par: message encoder for the lattice KEM datapath.
// Collects an N-bit message in IN_W-bit beats, then maps each message bit to
// the coefficient (OFFSET + bit*SCALE) mod Q, LANES coefficients per cycle,
// onto a flat N*COEF_W bus for the downstream polynomial adder.
// Optional build macro M_ENCODE_WIPE_EN: wipe the held message (and its valid
// flag) once an encode completes, so a message can be encoded only once.
module m_encode_par #(
  parameter int N      = 256,
  parameter int COEF_W = 12,
  parameter int Q      = 3329,
  parameter int SCALE  = 1665,
  parameter int OFFSET = 0,
  parameter int IN_W   = 8,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N*COEF_W-1:0]   m_out
);

  localparam int BEATS  = N / IN_W;
  localparam int STEPS  = N / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = (BEATS > 1) ? BEAT_W'(1) : '0;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  // Single conditional subtract of Q at COEF_W+1 bits; the sign of the
  // difference decides whether the subtraction is kept. Inputs are < 2*Q,
  // so the result is always < Q.
  function automatic logic [COEF_W-1:0] mod_reduce(input logic [COEF_W:0] x);
    logic signed [COEF_W+1:0] d;
    d = $signed({1'b0, x}) - $signed((COEF_W+2)'(Q));
    return (d < 0) ? x[COEF_W-1:0] : d[COEF_W-1:0];
  endfunction

  // Coefficient values for a 0 bit and a 1 bit are fixed per instance.
  localparam logic [COEF_W-1:0] ZERO_COEF = COEF_W'(OFFSET);
  localparam logic [COEF_W-1:0] ONE_COEF  = mod_reduce((COEF_W+1)'(OFFSET + SCALE));

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FULL,
    S_ENCODE,
    S_DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [STEP_W-1:0]   lane_cnt;
  logic                msg_valid;
  logic [N-1:0]        msg_q;
  logic [COEF_W-1:0]   coef_p0 [N];

  logic                accept;
  logic                enc_start;
  logic [BEAT_W-1:0]   wr_beat;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        // A beat takes priority over a simultaneous start.
        if (in_valid) begin
          state_d = (BEATS == 1) ? S_FULL : S_LOAD;
        end else if (start && msg_valid) begin
          state_d = S_ENCODE;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (beat_cnt == BEAT_LAST)) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (start) begin
          state_d = S_ENCODE;
        end
      end
      S_ENCODE: begin
        if (lane_cnt == STEP_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign enc_start = (state_q != S_ENCODE) && (state_d == S_ENCODE);
  // The first beat of a message always lands at index 0.
  assign wr_beat   = (state_q == S_IDLE) ? '0 : beat_cnt;

  // Beat and lane counters plus the message-valid flag; counters saturate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt  <= '0;
      lane_cnt  <= '0;
      msg_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (state_q == S_IDLE) begin
          beat_cnt <= BEAT_ONE;
        end else if (beat_cnt != BEAT_LAST) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end

      if (enc_start) begin
        lane_cnt <= '0;
      end else if ((state_q == S_ENCODE) && (lane_cnt != STEP_LAST)) begin
        lane_cnt <= lane_cnt + 1'b1;
      end

      if (accept && (state_q == S_IDLE)) begin
        msg_valid <= (BEATS == 1);
      end else if (accept && (state_q == S_LOAD) && (beat_cnt == BEAT_LAST)) begin
        msg_valid <= 1'b1;
      end
`ifdef M_ENCODE_WIPE_EN
      if (state_q == S_DONE) begin
        msg_valid <= 1'b0;
      end
`endif
    end
  end

  // Message store: each accepted beat fills its IN_W-bit slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_q <= '0;
    end else begin
      for (int b = 0; b < BEATS; b++) begin
        if (accept && (int'(wr_beat) == b)) begin
          msg_q[b*IN_W +: IN_W] <= in_data;
        end
      end
`ifdef M_ENCODE_WIPE_EN
      if (state_q == S_DONE) begin
        msg_q <= '0;
      end
`endif
    end
  end

  // ---- stage p0: encode the LANES coefficients selected by lane_cnt ----
  // Coefficients outside the active lane hold their value, so m_out only
  // changes during ENCODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        coef_p0[i] <= ZERO_COEF;
      end
    end else if (state_q == S_ENCODE) begin
      for (int i = 0; i < N; i++) begin
        if (int'(lane_cnt) == (i / LANES)) begin
          coef_p0[i] <= msg_q[i] ? ONE_COEF : ZERO_COEF;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign m_out[g*COEF_W +: COEF_W] = coef_p0[g];
  end

endmodule
